// File: rtl/oai21_arbiter.sv
// Round-robin arbiter sharing one oai21 gate among NREQ requesters.
// Optional OAI21_ARB_CHECK_EN builds a reference model that flags gate mismatches on err.
module oai21_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] a_in,
  input  logic [NREQ-1:0] b_in,
  input  logic [NREQ-1:0] c_in,
  output logic [NREQ-1:0] gnt,
  output logic            oai_a,
  output logic            oai_b,
  output logic            oai_c,
  input  logic            oai_y,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_y,
  output logic            busy,
  output logic            err
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EVAL = 1'b1;

  logic           state;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] w_q;
  logic [IDW-1:0] win;
  logic           found;
  int             idx;

  // Winner is the first set req bit at or above rr, wrapping to 0.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    win   = rr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  assign busy = (state == ST_EVAL);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr        <= '0;
      w_q       <= '0;
      gnt       <= '0;
      oai_a     <= 1'b0;
      oai_b     <= 1'b0;
      oai_c     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            oai_a <= a_in[win];
            oai_b <= b_in[win];
            oai_c <= c_in[win];
            w_q   <= win;
            state <= ST_EVAL;
          end else begin
            gnt <= '0;
          end
        end
        default: begin
          rsp_y     <= oai_y;
          rsp_id    <= w_q;
          rsp_valid <= 1'b1;
          rr        <= (w_q == IDW'(NREQ-1)) ? '0 : w_q + 1'b1;
          gnt       <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef OAI21_ARB_CHECK_EN
  logic model_y;
  logic err_q;

  assign model_y = ~((oai_a | oai_b) & oai_c);

  // Sticky until reset; compared at the capture edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   err_q <= 1'b0;
    else if (state == ST_EVAL && model_y != oai_y) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_oai21_arbiter.sv
// Scoreboard bench for oai21_arbiter: stimulus pushes expected responses, a monitor pops on rsp_valid.
module tb_oai21_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic       y;
  } rsp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req, a_in, b_in, c_in, gnt;
  logic       oai_a, oai_b, oai_c, oai_y;
  logic       rsp_valid, rsp_y, busy, err;
  logic [1:0] rsp_id;
  logic       force_y;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  oai21_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .oai_a(oai_a), .oai_b(oai_b), .oai_c(oai_c), .oai_y(oai_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy), .err(err)
  );

  // Shared gate, with an override to model a faulty cell.
  assign oai_y = force_y ? 1'b1 : ~((oai_a | oai_b) & oai_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      check("rsp_gnt_exclusive", gnt, 4'b0000);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_y", rsp_y, e.y);
      end
    end
  end

  // One arbitration: drive at a negedge, check grant one negedge later, end on the response negedge.
  task automatic do_op(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic frc, input logic [3:0] eg,
                       input logic [1:0] eid, input logic ey, input string nm);
    req = r; a_in = a; b_in = b; c_in = c; force_y = frc;
    @(negedge clk);
    check({nm, "_gnt"}, gnt, eg);
    check({nm, "_busy"}, busy, 1'b1);
    exp_q.push_back({eid, ey});
    req = 4'b0000;
    @(negedge clk);
    force_y = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] tbl;
    logic [3:0] rr_y;
    tbl  = 8'b0101_0111;  // oai21 result for abc = 7..0
    rr_y = 4'b1001;       // expected y per requester in the round-robin pattern

    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; c_in = '0; force_y = 1'b0;
    #12;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_oai", {oai_a, oai_b, oai_c}, 3'b000);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with all requests held: grants 0,1,2,3,0,1,2,3.
    req = 4'b1111; a_in = 4'b0101; b_in = 4'b0011; c_in = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_gnt", gnt, 4'b0001 << (i % 4));
      check("rr_no_rsp_in_gnt", rsp_valid, 1'b0);
      exp_q.push_back({2'(i % 4), rr_y[i % 4]});
      if (i == 7) req = 4'b0000;
      @(negedge clk);
      check("rr_gnt_low", gnt, 4'b0000);
    end

    // Single request on index 1: a=1 b=0 c=1 -> y=0.
    do_op(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "single");

    // All operand combinations on requester 0.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      do_op(4'b0001, {3'b0, abc[2]}, {3'b0, abc[1]}, {3'b0, abc[0]}, 1'b0,
            4'b0001, 2'd0, tbl[i], "exh");
    end

    // Move pointer to 3, then req=1001 grants 3 then wraps to 0.
    do_op(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "pre_wrap");
    do_op(4'b1001, 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, "wrap_hi");
    do_op(4'b1001, 4'b1001, 4'b0000, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0, "wrap_lo");

    // Faulty gate: abc=111 should give 0, forced to 1; rsp_y still reports the gate.
    do_op(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, "force");
    do_op(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, "after_force");
`ifdef OAI21_ARB_CHECK_EN
    check("err_sticky", err, 1'b1);
`else
    check("err_tied_low", err, 1'b0);
`endif

    // Reset mid-EVAL: pointer would be 0 after completion, 3 if reset failed to clear it.
    do_op(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, "pre_rst");
    req = 4'b1000; a_in = 4'b1000; b_in = 4'b1000; c_in = 4'b1000;
    @(negedge clk);
    check("midrst_busy", busy, 1'b1);
    check("midrst_oai_a", oai_a, 1'b1);
    req = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_busy_clr", busy, 1'b0);
    check("midrst_oai", {oai_a, oai_b, oai_c}, 3'b000);
    check("midrst_rsp", {rsp_valid, rsp_id, rsp_y}, 4'b0000);
    check("midrst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'b1010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "post_rst");

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
